// File: rtl/exp2_pkg.sv
// rtl/exp2_pkg.sv - shared constants, fraction table and stage types for exp2_pipe
package exp2_pkg;

  localparam int INT_W  = 5;
  localparam int FRAC_W = 4;
  localparam int MANT_W = 8;
  localparam int OUT_W  = 32;
  localparam int TAG_W  = 8;
  localparam int EXP_W  = INT_W + FRAC_W;

  // floor(256 * 2^(f/16)); the hidden leading one sits at bit MANT_W
  localparam logic [MANT_W:0] FRAC_LUT [0:(1<<FRAC_W)-1] = '{
    9'd256, 9'd267, 9'd279, 9'd291, 9'd304, 9'd317, 9'd331, 9'd346,
    9'd362, 9'd378, 9'd394, 9'd412, 9'd430, 9'd449, 9'd469, 9'd490
  };

  typedef struct packed {
    logic              valid;
    logic [INT_W-1:0]  shift;
    logic [MANT_W:0]   mant;
    logic [TAG_W-1:0]  tag;
  } cap_t;

  typedef struct packed {
    logic              valid;
    logic [OUT_W-1:0]  data;
    logic [TAG_W-1:0]  tag;
  } stage_t;

endpackage

// File: rtl/exp2_shift.sv
// rtl/exp2_shift.sv - combinational barrel shift of a table mantissa by n - MANT_W
module exp2_shift
  import exp2_pkg::*;
(
  input  logic [MANT_W:0]  mant,
  input  logic [INT_W-1:0] n,
  output logic [OUT_W-1:0] result
);

  localparam logic [INT_W-1:0] BIAS = INT_W'(MANT_W);

  logic [OUT_W-1:0] mant_ext;

  assign mant_ext = OUT_W'(mant);

  // Below the bias the fraction bits are floored away by the right shift
  always_comb begin
    result = '0;
    if (n >= BIAS) begin
      result = mant_ext << (n - BIAS);
    end else begin
      result = mant_ext >> (BIAS - n);
    end
  end

endmodule

// File: rtl/exp2_pipe.sv
// rtl/exp2_pipe.sv - three-stage floor(2^x) pipeline for unsigned Q5.4 exponents
module exp2_pipe
  import exp2_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  cap_t             s1;
  stage_t           s2;
  stage_t           s3;
  logic             s1_en;
  logic             s2_en;
  logic             s3_en;
  logic [OUT_W-1:0] shift_res;

  // A stage advances when it is empty or its successor advances this edge
  assign s3_en    = !s3.valid || out_ready;
  assign s2_en    = !s2.valid || s3_en;
  assign s1_en    = !s1.valid || s2_en;
  assign in_ready = s1_en;

  exp2_shift u_shift (
    .mant   (s1.mant),
    .n      (s1.shift),
    .result (shift_res)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
    end else if (s1_en) begin
      s1.valid <= in_valid;
      s1.shift <= in_exp[EXP_W-1:FRAC_W];
      s1.mant  <= FRAC_LUT[in_exp[FRAC_W-1:0]];
      s1.tag   <= in_tag;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2 <= '0;
    end else if (s2_en) begin
      s2.valid <= s1.valid;
      s2.data  <= shift_res;
      s2.tag   <= s1.tag;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s3 <= '0;
    end else if (s3_en) begin
      s3 <= s2;
    end
  end

  assign out_valid = s3.valid;
  assign out_data  = s3.data;
  assign out_tag   = s3.tag;
  assign busy      = s1.valid || s2.valid || s3.valid;

endmodule

// File: tb/tb_exp2_pipe.sv
// tb/tb_exp2_pipe.sv - self-checking bench for exp2_pipe against a floor(2^x) model
module tb_exp2_pipe;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [8:0]  in_exp = '0;
  logic [7:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [7:0]  out_tag;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rand_ready = 1'b0;

  logic [31:0] sb_data [$];
  logic [7:0]  sb_tag  [$];
  logic [31:0] log_data [$];
  logic [7:0]  log_tag  [$];
  int          log_cyc  [$];

  int unsigned lut [16] = '{256, 267, 279, 291, 304, 317, 331, 346,
                            362, 378, 394, 412, 430, 449, 469, 490};

  exp2_pipe dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_exp    (in_exp),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_exp2(input logic [8:0] x);
    longint unsigned m;
    m = longint'(lut[x[3:0]]);
    m = (m << x[8:4]) >> 8;
    return m[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [8:0] e, input logic [7:0] t);
    bit acc;
    int n;
    in_exp   = e;
    in_tag   = t;
    in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((busy || sb_data.size() != 0) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_sb_empty"}, 32'(sb_data.size()), 32'd0);
  endtask

  // Scoreboard: predict on input transfer, compare on output transfer
  initial begin
    logic        stall_prev;
    logic [31:0] prev_data;
    logic [7:0]  prev_tag;
    stall_prev = 1'b0;
    prev_data  = '0;
    prev_tag   = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset_n) begin
        if (stall_prev && out_valid) begin
          chk("stall_data", out_data, prev_data);
          chk("stall_tag", 32'(out_tag), 32'(prev_tag));
        end
        if (in_valid && in_ready) begin
          sb_data.push_back(ref_exp2(in_exp));
          sb_tag.push_back(in_tag);
        end
        if (out_valid && out_ready) begin
          if (sb_data.size() == 0) begin
            chk("sb_unexpected_output", out_data, 32'hDEADBEEF);
          end else begin
            chk("sb_data", out_data, sb_data.pop_front());
            chk("sb_tag", 32'(out_tag), 32'(sb_tag.pop_front()));
          end
          log_data.push_back(out_data);
          log_tag.push_back(out_tag);
          log_cyc.push_back(cyc);
        end
        stall_prev = out_valid && !out_ready;
        prev_data  = out_data;
        prev_tag   = out_tag;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    logic [8:0]  corner_exp [5];
    logic [31:0] corner_res [5];
    logic [8:0]  bp_exp [6];
    int          k;
    int          n;
    bit          accepted;

    corner_exp = '{9'h000, 9'h008, 9'h034, 9'h088, 9'h1FF};
    corner_res = '{32'd1, 32'd1, 32'd9, 32'd362, 32'hF5000000};
    bp_exp     = '{9'h0F0, 9'h101, 9'h0A3, 9'h07C, 9'h150, 9'h033};

    chk("model_5p0", ref_exp2(9'h050), 32'd32);
    chk("model_max", ref_exp2(9'h1FF), 32'hF5000000);
    chk("model_frac", ref_exp2(9'h088), 32'd362);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    reset_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Single operand latency
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_exp    = 9'h050;
    in_tag    = 8'h11;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("lat_e0_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_e1_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_e2_valid", 32'(out_valid), 32'd1);
    chk("lat_data", out_data, 32'd32);
    chk("lat_tag", 32'(out_tag), 32'h11);
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back corners
    log_data.delete();
    log_tag.delete();
    log_cyc.delete();
    for (int i = 0; i < 5; i++) send(corner_exp[i], 8'(8'h20 + i));
    in_valid = 1'b0;
    n = 0;
    while (log_data.size() < 5 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("stream_count", 32'(log_data.size()), 32'd5);
    if (log_data.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        chk("stream_data", log_data[i], corner_res[i]);
        chk("stream_tag", 32'(log_tag[i]), 32'(8'h20 + i));
        if (i > 0) chk("stream_rate", 32'(log_cyc[i] - log_cyc[i-1]), 32'd1);
      end
    end
    drain("stream");

    // Exhaustive sweep
    for (int x = 0; x < 512; x++) send(9'(x), 8'(x ^ 8'hA5));
    in_valid = 1'b0;
    drain("sweep");

    // Backpressure: hold out_ready low for 5 cycles
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      in_exp   = bp_exp[k];
      in_tag   = 8'(8'h40 + k);
      in_valid = 1'b1;
      @(negedge clk);
      accepted = in_ready;
      if (c == 3) chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      if (accepted) k++;
    end
    chk("bp_accepts", 32'(k), 32'd3);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    while (k < 6) begin
      send(bp_exp[k], 8'(8'h40 + k));
      k++;
    end
    in_valid = 1'b0;
    drain("bp");

    // Random valid/ready over 10k operands
    rand_ready = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send(9'($urandom_range(0, 511)), 8'($urandom_range(0, 255)));
    end
    in_valid   = 1'b0;
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain("rand");

    // Reset with the pipe full
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(9'(9'h020 + i), 8'(8'h70 + i));
    in_valid = 1'b0;
    chk("mid_busy_pre", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    sb_data.delete();
    sb_tag.delete();
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    send(9'h010, 8'h5A);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_data", out_data, 32'd2);
    chk("post_rst_tag", 32'(out_tag), 32'h5A);
    drain("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
